// File: rtl/param_assoc_cache.sv
// Parametrised N-way set-associative, write-back, write-allocate cache with a
// 256-bit line interface on both the CPU side and the memory side. Uses tree-PLRU
// replacement, fills the first invalid way, and keeps saturating hit/miss counters.
module param_assoc_cache #(
    parameter int unsigned WAYS  = 2,
    parameter int unsigned SETS  = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        mem_address,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        mem_byte_enable,
    input  logic [255:0]       mem_wdata,
    output logic [255:0]       mem_rdata,
    output logic               mem_resp,
    output logic [31:0]        pmem_address,
    output logic               pmem_read,
    output logic               pmem_write,
    input  logic [255:0]       pmem_rdata,
    output logic [255:0]       pmem_wdata,
    input  logic               pmem_resp,
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   miss_count
);

    localparam int unsigned IDX    = $clog2(SETS);
    localparam int unsigned TAG_W  = 27 - IDX;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned LVL    = $clog2(WAYS);
    localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    typedef enum logic [1:0] {StCheck, StWriteback, StFill} state_e;

    // Storage arrays; data and tags carry no reset
    logic [255:0]       data_q  [SETS][WAYS];
    logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
    logic [WAYS-1:0]    valid_q [SETS];
    logic [WAYS-1:0]    dirty_q [SETS];
    logic [PLRU_W-1:0]  plru_q  [SETS];

    state_e             state_q, state_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    logic               missed_q, missed_d;
    logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;

    logic [TAG_W-1:0]   req_tag;
    logic [IDX-1:0]     req_idx;
    logic               req;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic               inv_found;
    logic [WAY_W-1:0]   inv_way;
    logic [WAY_W-1:0]   plru_way;
    logic [WAY_W-1:0]   victim_sel;
    logic [PLRU_W-1:0]  plru_next;
    logic [255:0]       merged_line;
    logic               miss_evt;
    logic               hit_evt;
    logic               fill_evt;
    logic               wb_done;
    logic               unused_offset;

    assign req_tag       = mem_address[31:5+IDX];
    assign req_idx       = mem_address[4+IDX:5];
    assign req           = mem_read | mem_write;
    assign unused_offset = ^mem_address[4:0];
    assign hit_count     = hit_cnt_q;
    assign miss_count    = miss_cnt_q;

    // Tag compare across the ways of the indexed set; at most one way matches
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest-index invalid way takes priority over the PLRU choice
    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!valid_q[req_idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim_sel = inv_found ? inv_way : plru_way;
    end

    // Tree-PLRU: bit per node in heap order, 1 means the LRU side is the right subtree
    if (WAYS > 1) begin : g_plru
        // Walk the tree from the root following the LRU pointers
        always_comb begin : plru_find
            int unsigned       node;
            logic [PLRU_W-1:0] bits_sh;
            node    = 1;
            bits_sh = '0;
            for (int unsigned l = 0; l < LVL; l++) begin
                bits_sh = plru_q[req_idx] >> (node - 1);
                node    = 2 * node + 32'(bits_sh[0]);
            end
            plru_way = WAY_W'(node - WAYS);
        end

        // Point every node on the hit way's path away from that way
        always_comb begin : plru_touch
            int unsigned       node;
            logic [WAY_W-1:0]  way_sh;
            logic [PLRU_W-1:0] mask;
            plru_next = plru_q[req_idx];
            node      = 1;
            way_sh    = '0;
            mask      = '0;
            for (int unsigned l = 0; l < LVL; l++) begin
                way_sh = hit_way >> (LVL - 1 - l);
                mask   = PLRU_W'(1) << (node - 1);
                if (way_sh[0]) begin
                    plru_next = plru_next & ~mask;
                end else begin
                    plru_next = plru_next | mask;
                end
                node = 2 * node + 32'(way_sh[0]);
            end
        end
    end else begin : g_no_plru
        assign plru_way  = '0;
        assign plru_next = '0;
    end

    // Byte-merge of the CPU write data into the hit line
    always_comb begin
        merged_line = data_q[req_idx][hit_way];
        for (int i = 0; i < 32; i++) begin
            if (mem_byte_enable[i]) begin
                merged_line[i*8 +: 8] = mem_wdata[i*8 +: 8];
            end
        end
    end

    // Next-state and output decode for the CHECK / WRITEBACK / FILL controller
    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        missed_d     = missed_q;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        miss_evt     = 1'b0;
        hit_evt      = 1'b0;
        fill_evt     = 1'b0;
        wb_done      = 1'b0;
        case (state_q)
            StCheck: begin
                if (req) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        if (mem_read) begin
                            mem_rdata = data_q[req_idx][hit_way];
                        end
                        hit_evt  = !missed_q;
                        missed_d = 1'b0;
                    end else begin
                        miss_evt = 1'b1;
                        missed_d = 1'b1;
                        victim_d = victim_sel;
                        // Only a valid line can be dirty, so this covers both cases
                        state_d  = dirty_q[req_idx][victim_sel] ? StWriteback : StFill;
                    end
                end
            end
            StWriteback: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[req_idx][victim_q], req_idx, 5'b0};
                pmem_wdata   = data_q[req_idx][victim_q];
                if (pmem_resp) begin
                    wb_done = 1'b1;
                    state_d = StFill;
                end
            end
            StFill: begin
                pmem_read    = 1'b1;
                pmem_address = {mem_address[31:5], 5'b0};
                if (pmem_resp) begin
                    fill_evt = 1'b1;
                    state_d  = StCheck;
                end
            end
            default: state_d = StCheck;
        endcase
    end

    // Controller state, line status bits, PLRU and saturating counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StCheck;
            victim_q   <= '0;
            missed_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            missed_q <= missed_d;
            if (hit_evt && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            end
            if (miss_evt && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
            if (mem_resp) begin
                plru_q[req_idx] <= plru_next;
                if (mem_write) begin
                    dirty_q[req_idx][hit_way] <= 1'b1;
                end
            end
            if (wb_done) begin
                dirty_q[req_idx][victim_q] <= 1'b0;
            end
            if (fill_evt) begin
                valid_q[req_idx][victim_q] <= 1'b1;
                dirty_q[req_idx][victim_q] <= 1'b0;
            end
        end
    end

    // Line data and tag storage: refill from memory or byte-merged CPU write
    always_ff @(posedge clk) begin
        if (fill_evt) begin
            data_q[req_idx][victim_q] <= pmem_rdata;
            tag_q[req_idx][victim_q]  <= req_tag;
        end else if (mem_resp && mem_write) begin
            data_q[req_idx][hit_way] <= merged_line;
        end
    end

endmodule

// File: tb/tb_param_assoc_cache.sv
// Self-checking bench for param_assoc_cache: a recency-list cache model predicts
// hit/miss, latency, counters and memory-side traffic; a monitor and a memory
// responder compare the DUT against the queued expectations.
module tb_param_assoc_cache;

    localparam int unsigned WAYS  = 2;
    localparam int unsigned SETS  = 16;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned LAT   = 3;
    localparam int unsigned IDX   = $clog2(SETS);

    logic               clk;
    logic               rst;
    logic [31:0]        mem_address;
    logic               mem_read;
    logic               mem_write;
    logic [31:0]        mem_byte_enable;
    logic [255:0]       mem_wdata;
    logic [255:0]       mem_rdata;
    logic               mem_resp;
    logic [31:0]        pmem_address;
    logic               pmem_read;
    logic               pmem_write;
    logic [255:0]       pmem_rdata;
    logic [255:0]       pmem_wdata;
    logic               pmem_resp;
    logic [CNT_W-1:0]   hit_count;
    logic [CNT_W-1:0]   miss_count;

    param_assoc_cache #(.WAYS(WAYS), .SETS(SETS), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_rdata      (pmem_rdata),
        .pmem_wdata      (pmem_wdata),
        .pmem_resp       (pmem_resp),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit               rd;
        logic [255:0]     data;
        int               lat;
        logic [CNT_W-1:0] hits;
        logic [CNT_W-1:0] misses;
    } sb_t;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } pm_t;

    sb_t              sb_q[$];
    pm_t              pm_q[$];
    logic [255:0]     golden   [bit [26:0]];
    logic [255:0]     pmem_mem [bit [26:0]];
    bit [26:0]        cached[$];
    bit               dirty_m  [bit [26:0]];
    logic [CNT_W-1:0] hit_m;
    logic [CNT_W-1:0] miss_m;
    int               checks = 0;
    int               passed = 0;
    int               stray_req = 0;

    function automatic logic [255:0] init_line(bit [26:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = {la, 5'b0} ^ (32'(i + 1) * 32'h9E37_79B9);
        return l;
    endfunction

    function automatic logic [255:0] gold_line(bit [26:0] la);
        return golden.exists(la) ? golden[la] : init_line(la);
    endfunction

    function automatic logic [255:0] pmem_line(bit [26:0] la);
        return pmem_mem.exists(la) ? pmem_mem[la] : init_line(la);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    task automatic check_val(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: per-set LRU over a recency list (exact for 2 ways), golden CPU view
    task automatic model_req(input logic [31:0] addr, input bit wr, input logic [31:0] be,
                             input logic [255:0] wd);
        bit [26:0]    la;
        bit [26:0]    v;
        int           pos;
        int           lru_pos;
        int           cnt;
        sb_t          e;
        pm_t          p;
        logic [255:0] line;
        la      = addr[31:5];
        pos     = -1;
        lru_pos = -1;
        cnt     = 0;
        for (int i = 0; i < cached.size(); i++) begin
            if (cached[i] == la) pos = i;
            if (cached[i][IDX-1:0] == la[IDX-1:0]) begin
                cnt++;
                if (lru_pos < 0) lru_pos = i;
            end
        end
        e.lat = 1;
        if (pos >= 0) begin
            cached.delete(pos);
            cached.push_back(la);
        end else begin
            miss_m = sat_inc(miss_m);
            if (cnt == WAYS) begin
                v = cached[lru_pos];
                cached.delete(lru_pos);
                if (dirty_m.exists(v)) begin
                    p.wr = 1'b1; p.addr = {v, 5'b0}; p.data = gold_line(v);
                    pm_q.push_back(p);
                    dirty_m.delete(v);
                    e.lat += LAT;
                end
            end
            p.wr = 1'b0; p.addr = {la, 5'b0}; p.data = '0;
            pm_q.push_back(p);
            e.lat += LAT + 1;
            cached.push_back(la);
        end
        e.misses = miss_m;
        e.hits   = hit_m;
        if (pos >= 0) hit_m = sat_inc(hit_m);
        if (wr) begin
            line = gold_line(la);
            for (int i = 0; i < 32; i++) if (be[i]) line[i*8 +: 8] = wd[i*8 +: 8];
            golden[la] = line;
            dirty_m[la] = 1'b1;
        end
        e.rd   = !wr;
        e.data = gold_line(la);
        sb_q.push_back(e);
    endtask

    task automatic do_req(input logic [31:0] addr, input bit wr, input logic [31:0] be,
                          input logic [255:0] wd);
        bit done;
        done = 1'b0;
        model_req(addr, wr, be, wd);
        @(posedge clk); #1;
        mem_address     = addr;
        mem_read        = !wr;
        mem_write       = wr;
        mem_byte_enable = be;
        mem_wdata       = wd;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (mem_resp) done = 1'b1;
        end
        if (!done) begin
            checks++;
            $display("FAIL req_timeout: no mem_resp for addr %h, required within 100 cycles", addr);
            sb_q.delete();
            pm_q.delete();
        end
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic rand_req();
        bit [26:0] la;
        bit [31:0] tag;
        case ($urandom_range(0, 4))
            0: tag = 32'h0;
            1: tag = 32'h1;
            2: tag = 32'h2;
            3: tag = 32'h3;
            default: tag = 32'h12345;
        endcase
        la = 27'(tag << IDX) | 27'($urandom_range(0, 3));
        do_req({la, 5'($urandom)}, ($urandom_range(0, 9) < 4), $urandom, {8{$urandom}});
    endtask

    // Monitor: compare every completed CPU request against the scoreboard head
    initial begin : monitor
        int  mcyc;
        sb_t e;
        mcyc = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mcyc = 0;
            end else begin
                if (mem_read || mem_write) mcyc++;
                if (mem_resp) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_resp: mem_resp with empty scoreboard, addr %h",
                                 mem_address);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.rd) check_val("rdata", mem_rdata, e.data);
                        check_val("latency", 256'(mcyc), 256'(e.lat));
                        check_val("hit_count", 256'(hit_count), 256'(e.hits));
                        check_val("miss_count", 256'(miss_count), 256'(e.misses));
                    end
                    mcyc = 0;
                end
            end
        end
    end

    // Memory responder: fixed latency, checks each transaction against the model
    initial begin : responder
        int  pcnt;
        int  stray_seen;
        pm_t x;
        pcnt       = 0;
        stray_seen = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (!rst) begin
                pcnt = 0;
            end else if (stray_req != stray_seen) begin
                stray_seen = stray_req;
                pmem_resp  = 1'b1;
                pmem_rdata = {8{$urandom}};
            end else if (pmem_read || pmem_write) begin
                pcnt++;
                if (pcnt == LAT) begin
                    pcnt = 0;
                    check_val("pmem_excl", 256'(pmem_read & pmem_write), 256'(0));
                    if (pm_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_pmem: wr=%0b addr %h with nothing expected",
                                 pmem_write, pmem_address);
                    end else begin
                        x = pm_q.pop_front();
                        check_val("pmem_kind", 256'(pmem_write), 256'(x.wr));
                        check_val("pmem_addr", 256'(pmem_address), 256'(x.addr));
                        if (x.wr) check_val("pmem_wdata", pmem_wdata, x.data);
                    end
                    if (pmem_write) pmem_mem[pmem_address[31:5]] = pmem_wdata;
                    else pmem_rdata = pmem_line(pmem_address[31:5]);
                    pmem_resp = 1'b1;
                end
            end
        end
    end

    initial begin : main
        logic [31:0] raddr;
        bit          seen;
        pm_t         p;
        rst             = 1'b0;
        mem_address     = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = '0;
        mem_wdata       = '0;
        hit_m           = '0;
        miss_m          = '0;
        #3;
        check_val("rst_mem_resp", 256'(mem_resp), 256'(0));
        check_val("rst_pmem_read", 256'(pmem_read), 256'(0));
        check_val("rst_pmem_write", 256'(pmem_write), 256'(0));
        check_val("rst_mem_rdata", mem_rdata, '0);
        check_val("rst_pmem_address", 256'(pmem_address), 256'(0));
        check_val("rst_pmem_wdata", pmem_wdata, '0);
        check_val("rst_hit_count", 256'(hit_count), 256'(0));
        check_val("rst_miss_count", 256'(miss_count), 256'(0));
        #10 rst = 1'b1;

        // Cold miss, hit, partial write, merged read, then dirty PLRU eviction
        do_req(32'h0000_1000, 1'b0, 32'h0, '0);
        do_req(32'h0000_1004, 1'b0, 32'h0, '0);
        do_req(32'h0000_1000, 1'b1, 32'h0000_000F, {32{8'hAA}});
        do_req(32'h0000_1000, 1'b0, 32'h0, '0);
        do_req(32'h0000_2000, 1'b0, 32'h0, '0);
        do_req(32'h0000_3000, 1'b0, 32'h0, '0);

        for (int i = 0; i < 250; i++) rand_req();

        // Reset in the middle of a fill
        raddr = {27'(32'h7ff << IDX) | 27'd5, 5'b0};
        p.wr = 1'b0; p.addr = raddr; p.data = '0;
        pm_q.push_back(p);
        @(posedge clk); #1;
        mem_address = raddr;
        mem_read    = 1'b1;
        seen        = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (pmem_read) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            $display("FAIL fill_timeout: pmem_read never rose for %h", raddr);
        end
        #2 rst = 1'b0;
        #1;
        check_val("rstmid_pmem_read", 256'(pmem_read), 256'(0));
        check_val("rstmid_pmem_write", 256'(pmem_write), 256'(0));
        check_val("rstmid_mem_resp", 256'(mem_resp), 256'(0));
        check_val("rstmid_miss_count", 256'(miss_count), 256'(0));
        mem_read = 1'b0;
        pm_q.delete();
        sb_q.delete();
        cached.delete();
        dirty_m.delete();
        golden = pmem_mem;
        hit_m  = '0;
        miss_m = '0;
        @(negedge clk); #2 rst = 1'b1;
        stray_req++;
        repeat (3) @(posedge clk);

        do_req(raddr, 1'b0, 32'h0, '0);
        do_req(32'h0000_1000, 1'b0, 32'h0, '0);
        for (int i = 0; i < 40; i++) rand_req();

        repeat (5) @(posedge clk);
        check_val("sb_drained", 256'(sb_q.size()), 256'(0));
        check_val("pmem_drained", 256'(pm_q.size()), 256'(0));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
